// File: rtl/mod_multicycle_control_if.sv
// -----------------------------------------------------------------------------
// mod_multicycle_control_if
// Bundle of signals between the multicycle control FSM and the shared datapath.
//   master : the control unit. Receives opcode/funct from the IR and mem_ready
//            from the memory port; drives every load enable, mux select,
//            memory strobe and status flag.
//   slave  : the datapath/memory side. Drives opcode/funct/mem_ready and
//            consumes the controls.
// ALU_OP_W sets the width of alu_op; only bits [2:0] carry an encoding.
// -----------------------------------------------------------------------------
interface mod_multicycle_control_if #(
    parameter int ALU_OP_W = 3
);
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                mem_ready;

    logic                pc_write;
    logic                pc_write_cond;
    logic                ir_write;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          pc_source;
    logic                instr_done;
    logic                illegal_op;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op
    );
endinterface

// File: rtl/mod_multicycle_control.sv
// -----------------------------------------------------------------------------
// mod_multicycle_control
// Moore-style control FSM for a multicycle MIPS datapath. Sequences fetch,
// decode, execute, memory and write-back over several clocks and shares a
// single memory port that completes when mem_ready is high.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; forces IDLE immediately
//   bus   - master side of mod_multicycle_control_if (opcode/funct/mem_ready
//           in, all datapath controls and instr_done/illegal_op out)
// Parameters:
//   ALU_OP_W    - width of alu_op (>= 3); upper bits are always 0
//   ENABLE_ADDI - 1 decodes addi, 0 sends it to TRAP
// Outputs are decoded combinationally from the state register, with the
// mem_ready-dependent extras in FETCH/MEM_WR and funct-driven alu_op in the
// R-type states. Because the state flop resets asynchronously, every output
// falls to its idle value the moment rst_n goes low.
// -----------------------------------------------------------------------------
module mod_multicycle_control #(
    parameter int ALU_OP_W    = 3,
    parameter bit ENABLE_ADDI = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    mod_multicycle_control_if.master        bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EXEC,
        S_R_WB,
        S_BRANCH,
        S_JUMP,
        S_ADDI_EXEC,
        S_ADDI_WB,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOP = 3'b101;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

    function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
        logic [2:0] op;
        case (f)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

    state_t state_q;
    state_t state_d;

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW))
                    state_d = S_MEM_ADDR;
                else if ((bus.opcode == OP_R) && funct_legal(bus.funct))
                    state_d = S_R_EXEC;
                else if (bus.opcode == OP_BEQ)
                    state_d = S_BRANCH;
                else if (bus.opcode == OP_J)
                    state_d = S_JUMP;
                else if (ENABLE_ADDI && (bus.opcode == OP_ADDI))
                    state_d = S_ADDI_EXEC;
                else
                    state_d = S_TRAP;
            end
            // Only lw/sw can reach MEM_ADDR, and opcode is stable until FETCH.
            S_MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WR:    if (bus.mem_ready) state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;   // only reset leaves TRAP
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    logic [2:0]          alu3;
    logic [ALU_OP_W-1:0] alu_full;

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.ir_write      = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.pc_source     = 2'b00;
        bus.instr_done    = 1'b0;
        bus.illegal_op    = 1'b0;
        alu3              = ALU_NOP;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                alu3          = ALU_ADD;
                // IR and PC load together in the cycle the fetch completes.
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;   // precompute branch target
                alu3          = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                alu3          = ALU_ADD;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write  = 1'b1;
                bus.i_or_d     = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            S_R_EXEC: begin
                bus.alu_src_a = 1'b1;
                alu3          = funct_to_alu(bus.funct);
            end
            S_R_WB: begin
                bus.reg_dst    = 1'b1;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                alu3           = funct_to_alu(bus.funct);
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
                bus.instr_done    = 1'b1;
                alu3              = ALU_SUB;
            end
            S_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = 2'b10;
                bus.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                bus.reg_write  = 1'b1;
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.instr_done = 1'b1;
                alu3           = ALU_ADD;
            end
            // Sticky by construction: TRAP is absorbing until reset.
            S_TRAP:  bus.illegal_op = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        alu_full      = '0;
        alu_full[2:0] = alu3;
    end

    assign bus.alu_op = alu_full;

endmodule

// File: tb/tb_mod_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_mod_multicycle_control
// Directed bench: walks the control FSM through every instruction class,
// memory stalls, illegal opcodes and an asynchronous reset mid-store. A second
// instance with addi disabled runs in parallel on the same clock and reset.
// -----------------------------------------------------------------------------
module tb_mod_multicycle_control;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    mod_multicycle_control_if #(.ALU_OP_W(4)) bus_if ();
    mod_multicycle_control_if #(.ALU_OP_W(3)) bus0_if ();

    mod_multicycle_control #(.ALU_OP_W(4), .ENABLE_ADDI(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    mod_multicycle_control #(.ALU_OP_W(3), .ENABLE_ADDI(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0_if)
    );

    always #5 clk = ~clk;

    // Flattened output view of the main DUT:
    // {pcw,pcwc,irw,iord,mrd,mwr,m2r,rdst,rwr,srca,srcb[1:0],aluop[3:0],psrc[1:0],done,ill}
    logic [19:0] obs;
    assign obs = {bus_if.pc_write, bus_if.pc_write_cond, bus_if.ir_write,
                  bus_if.i_or_d, bus_if.mem_read, bus_if.mem_write,
                  bus_if.mem_to_reg, bus_if.reg_dst, bus_if.reg_write,
                  bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op,
                  bus_if.pc_source, bus_if.instr_done, bus_if.illegal_op};

    function automatic logic [19:0] ev(
        input bit pcw, input bit pcwc, input bit irw, input bit iod,
        input bit mr, input bit mw, input bit m2r, input bit rd, input bit rw,
        input bit asa, input bit [1:0] asb, input bit [3:0] aop,
        input bit [1:0] psrc, input bit done, input bit ill);
        return {pcw, pcwc, irw, iod, mr, mw, m2r, rd, rw, asa, asb, aop, psrc, done, ill};
    endfunction

    task automatic chk(input string tag, input logic [19:0] o, input logic [19:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
        end
        $display("t=%0t %s observed=%05h expected=%05h", $time, tag, o, e);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [19:0] v_idle, v_fstall, v_frdy, v_dec, v_maddr, v_mrd, v_mwb;
        logic [19:0] v_mwr, v_mwrd, v_rex_add, v_rwb_add, v_rex_slt, v_rwb_slt;
        logic [19:0] v_br, v_jmp, v_awb, v_trap;

        //                pcw pcwc irw iod mr mw m2r rd rw asa asb    aop      psrc  done ill
        v_idle    = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0101, 2'b00, 0, 0);
        v_fstall  = ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 4'b0010, 2'b00, 0, 0);
        v_frdy    = ev(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 4'b0010, 2'b00, 0, 0);
        v_dec     = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0010, 2'b00, 0, 0);
        v_maddr   = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0010, 2'b00, 0, 0);
        v_mrd     = ev(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0101, 2'b00, 0, 0);
        v_mwb     = ev(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 4'b0101, 2'b00, 1, 0);
        v_mwr     = ev(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0101, 2'b00, 0, 0);
        v_mwrd    = ev(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0101, 2'b00, 1, 0);
        v_rex_add = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0010, 2'b00, 0, 0);
        v_rwb_add = ev(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 4'b0010, 2'b00, 1, 0);
        v_rex_slt = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0111, 2'b00, 0, 0);
        v_rwb_slt = ev(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 4'b0111, 2'b00, 1, 0);
        v_br      = ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0110, 2'b01, 1, 0);
        v_jmp     = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0101, 2'b10, 1, 0);
        v_awb     = ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10, 4'b0010, 2'b00, 1, 0);
        v_trap    = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0101, 2'b00, 0, 1);

        bus_if.opcode     = 6'b000000;
        bus_if.funct      = 6'b100000;
        bus_if.mem_ready  = 1'b1;
        bus0_if.opcode    = 6'b001000;   // addi: illegal in dut0
        bus0_if.funct     = 6'b000000;
        bus0_if.mem_ready = 1'b1;

        // ---- reset, then R-type add
        #1 rst_n = 1'b0;
        #1 chk("reset_idle", obs, v_idle);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("idle_after_release", obs, v_idle);
        nxt; chk("r_fetch", obs, v_frdy);
        nxt; chk("r_decode", obs, v_dec);
        chk("addi_dis_decode", 20'(bus0_if.illegal_op), 20'd0);
        nxt; chk("r_exec_add", obs, v_rex_add);
        chk("addi_dis_trap", 20'(bus0_if.illegal_op), 20'd1);
        nxt; chk("r_wb_add_cycle4", obs, v_rwb_add);

        // ---- R-type slt
        bus_if.funct = 6'b101010;
        nxt; chk("slt_fetch", obs, v_frdy);
        nxt; chk("slt_decode", obs, v_dec);
        nxt; chk("slt_exec", obs, v_rex_slt);
        nxt; chk("slt_wb", obs, v_rwb_slt);

        // ---- lw with two MEM_RD stall cycles (mem_ready ignored in DECODE)
        bus_if.opcode = 6'b100011;
        nxt; chk("lw_fetch", obs, v_frdy);
        nxt; bus_if.mem_ready = 1'b0;
        #1 chk("lw_decode", obs, v_dec);
        nxt; chk("lw_maddr", obs, v_maddr);
        nxt; chk("lw_mrd_stall1", obs, v_mrd);
        nxt; chk("lw_mrd_stall2", obs, v_mrd);
        nxt; bus_if.mem_ready = 1'b1;
        #1 chk("lw_mrd_ready", obs, v_mrd);
        nxt; chk("lw_mwb_cycle7", obs, v_mwb);

        // ---- sw, with one FETCH stall
        bus_if.opcode = 6'b101011;
        nxt; bus_if.mem_ready = 1'b0;
        #1 chk("sw_fetch_stall", obs, v_fstall);
        bus_if.mem_ready = 1'b1;
        #1 chk("sw_fetch_ready", obs, v_frdy);
        nxt; chk("sw_decode", obs, v_dec);
        nxt; chk("sw_maddr", obs, v_maddr);
        nxt; chk("sw_mwr_done", obs, v_mwrd);
        nxt; chk("sw_back_fetch", obs, v_frdy);

        // ---- beq then j
        bus_if.opcode = 6'b000100;
        nxt; chk("beq_decode", obs, v_dec);
        nxt; chk("beq_branch", obs, v_br);
        bus_if.opcode = 6'b000010;
        nxt; chk("j_fetch", obs, v_frdy);
        nxt; chk("j_decode", obs, v_dec);
        nxt; chk("j_jump", obs, v_jmp);

        // ---- addi (enabled)
        bus_if.opcode = 6'b001000;
        nxt; chk("addi_fetch", obs, v_frdy);
        nxt; chk("addi_decode", obs, v_dec);
        nxt; chk("addi_exec", obs, v_maddr);
        nxt; chk("addi_wb", obs, v_awb);

        // ---- illegal opcode traps and holds regardless of inputs
        bus_if.opcode = 6'b111111;
        nxt; chk("ill_fetch", obs, v_frdy);
        nxt; chk("ill_decode", obs, v_dec);
        for (int i = 0; i < 12; i++) begin
            nxt; chk("trap_hold", obs, v_trap);
            bus_if.opcode    = 6'($urandom);
            bus_if.funct     = 6'($urandom);
            bus_if.mem_ready = 1'($urandom);
        end
        chk("addi_dis_hold", 20'(bus0_if.illegal_op), 20'd1);
        #2 rst_n = 1'b0;
        #1 chk("trap_clear", obs, v_idle);
        chk("addi_dis_clear", 20'(bus0_if.illegal_op), 20'd0);
        bus_if.opcode    = 6'b101011;
        bus_if.funct     = 6'b100000;
        bus_if.mem_ready = 1'b1;
        #3 rst_n = 1'b1;

        // ---- reset mid MEM_WR with memory stalled
        nxt; chk("mr_fetch", obs, v_frdy);
        nxt; chk("mr_decode", obs, v_dec);
        nxt; chk("mr_maddr", obs, v_maddr);
        nxt; bus_if.mem_ready = 1'b0;
        #1 chk("mr_mwr_stall", obs, v_mwr);
        nxt; chk("mr_mwr_stall2", obs, v_mwr);
        #2 rst_n = 1'b0;
        #1 chk("mr_async_idle", obs, v_idle);
        bus_if.mem_ready = 1'b1;
        #3 rst_n = 1'b1;
        #1 chk("mr_idle_hold", obs, v_idle);
        nxt; chk("mr_restart_fetch", obs, v_frdy);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
